// File: rtl/bist_fail_logger.sv
`default_nettype none
//============================================================================
// Module   : bist_fail_logger
// Purpose  : Collects compare records from a March C- BIST controller. It
//            keeps a saturating count of failing reads and logs the first
//            LOG_DEPTH failures in arrival order. It reports pass/fail/done
//            status, and the log can be drained after the run through a
//            single-entry read port.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            test_start          - pulse: clear everything, start collecting
//            test_done           - pulse: controller finished its run
//            cmp_valid/addr/expected/actual/element - compare record
//            log_rd_en           - pop the oldest log entry (DONE only)
//            log_rd_valid/addr/element/syndrome     - popped entry
//            log_count           - entries currently held
//            log_overflow        - sticky, a failure found the log full
//            fail_count          - saturating total failure count
//            bist_fail           - fail_count is non-zero
//            bist_done           - run finished and pipeline drained
// Revision : 1.0 - initial release
//============================================================================
module bist_fail_logger #(
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 32,
   parameter int LOG_DEPTH = 8,
   parameter int CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         test_start,
   input  logic                         test_done,
   input  logic                         cmp_valid,
   input  logic [ADDR_W-1:0]            cmp_addr,
   input  logic [DATA_W-1:0]            cmp_expected,
   input  logic [DATA_W-1:0]            cmp_actual,
   input  logic [2:0]                   cmp_element,
   input  logic                         log_rd_en,
   output logic                         log_rd_valid,
   output logic [ADDR_W-1:0]            log_rd_addr,
   output logic [2:0]                   log_rd_element,
   output logic [DATA_W-1:0]            log_rd_syndrome,
   output logic [$clog2(LOG_DEPTH):0]   log_count,
   output logic                         log_overflow,
   output logic [CNT_W-1:0]             fail_count,
   output logic                         bist_fail,
   output logic                         bist_done
);

   localparam int PW = $clog2(LOG_DEPTH);
   localparam int EW = ADDR_W + 3 + DATA_W;
   localparam logic [PW:0] c_DEPTH = (PW+1)'(LOG_DEPTH);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0] state_q, state_d;
   logic       w_collect;
   logic       w_done;

   //------------------------------------------------------------------
   // FSM: state register / next state / outputs
   //------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (test_start) begin
         state_d = S_COLLECT;
      end else begin
         case (state_q)
            S_IDLE:    state_d = S_IDLE;
            S_COLLECT: if (test_done) state_d = S_DRAIN;
            // One cycle lets the last accepted record finish stage 2.
            S_DRAIN:   state_d = S_DONE;
            S_DONE:    state_d = S_DONE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_collect = (state_q == S_COLLECT);
      w_done    = (state_q == S_DONE);
   end

   //------------------------------------------------------------------
   // Stage 1: capture the record and its syndrome
   //------------------------------------------------------------------
   logic              s1_valid_q, s1_valid_d;
   logic [ADDR_W-1:0] s1_addr_q;
   logic [2:0]        s1_elem_q;
   logic [DATA_W-1:0] s1_syn_q;

   // A record arriving with test_start belongs to neither run and is dropped.
   assign s1_valid_d = cmp_valid & w_collect & ~test_start;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         s1_elem_q  <= '0;
         s1_syn_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (s1_valid_d) begin
            s1_addr_q <= cmp_addr;
            s1_elem_q <= cmp_element;
            s1_syn_q  <= cmp_expected ^ cmp_actual;
         end
      end
   end

   //------------------------------------------------------------------
   // Stage 2: mismatch detect, fail count and log bookkeeping
   //------------------------------------------------------------------
   logic [EW-1:0]    mem_q [LOG_DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PW:0]      count_q, count_d;
   logic [CNT_W-1:0] fail_q, fail_d;
   logic             ovf_q, ovf_d;
   logic             w_mismatch, w_full, w_wr, w_pop;

   assign w_mismatch = s1_valid_q & (s1_syn_q != '0);
   assign w_full     = (count_q == c_DEPTH);
   assign w_wr       = w_mismatch & ~w_full & ~test_start;
   assign w_pop      = log_rd_en & w_done & (count_q != '0) & ~test_start;

   always_comb begin
      count_d = count_q;
      fail_d  = fail_q;
      ovf_d   = ovf_q;
      if (test_start) begin
         count_d = '0;
         fail_d  = '0;
         ovf_d   = 1'b0;
      end else begin
         case ({w_wr, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         // Saturate rather than wrap so a large fail count never reads as a pass.
         if (w_mismatch && (fail_q != '1)) fail_d = fail_q + 1'b1;
         if (w_mismatch && w_full)         ovf_d  = 1'b1;
      end
   end

   // Pointers are PW bits wide so they wrap modulo LOG_DEPTH on their own;
   // count_q carries the full/empty distinction.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         fail_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         fail_q  <= fail_d;
         ovf_q   <= ovf_d;
         if (test_start) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (w_wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Log storage is not reset; occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (w_wr) mem_q[wr_ptr_q] <= {s1_addr_q, s1_elem_q, s1_syn_q};
   end

   //------------------------------------------------------------------
   // Readout register: holds the last popped entry
   //------------------------------------------------------------------
   logic              rd_valid_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [2:0]        rd_elem_q;
   logic [DATA_W-1:0] rd_syn_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         rd_elem_q  <= '0;
         rd_syn_q   <= '0;
      end else begin
         rd_valid_q <= w_pop;
         if (w_pop) begin
            {rd_addr_q, rd_elem_q, rd_syn_q} <= mem_q[rd_ptr_q];
         end
      end
   end

   assign log_rd_valid    = rd_valid_q;
   assign log_rd_addr     = rd_addr_q;
   assign log_rd_element  = rd_elem_q;
   assign log_rd_syndrome = rd_syn_q;
   assign log_count       = count_q;
   assign log_overflow    = ovf_q;
   assign fail_count      = fail_q;
   assign bist_fail       = |fail_q;
   assign bist_done       = w_done;

endmodule
`default_nettype wire

// File: doc/bist_fail_logger.md
Name: bist_fail_logger

Overview:
- Downstream of the March C- BIST controller (mem_e8kw32s test).
- Consumes one compare record per read (address, expected, actual, march element) and keeps a saturating fail count.
- Logs the first LOG_DEPTH failing reads in an in-order buffer and reports pass/fail/done.
- The captured log can be drained after the run through a simple read port for debug and repair analysis.

Parameters:
ADDR_W, 14, compare address width
DATA_W, 32, data word width
LOG_DEPTH, 8, failure log entries (power of two, >=2)
CNT_W, 16, total fail counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
test_start  in  1  pulse: clear log and counters, begin collecting
test_done  in  1  pulse: controller reached COMPLETE
cmp_valid  in  1  compare record valid this cycle
cmp_addr  in  ADDR_W  address of the read
cmp_expected  in  DATA_W  expected pattern
cmp_actual  in  DATA_W  memory read data
cmp_element  in  3  march element 1..6
log_rd_en  in  1  pop oldest log entry
log_rd_valid  out  1  popped entry valid (one-cycle pulse)
log_rd_addr  out  ADDR_W  popped failing address
log_rd_element  out  3  popped march element
log_rd_syndrome  out  DATA_W  popped expected XOR actual
log_count  out  $clog2(LOG_DEPTH)+1  entries held
log_overflow  out  1  sticky: a failure arrived while the log was full
fail_count  out  CNT_W  total failures, saturating
bist_fail  out  1  fail_count != 0
bist_done  out  1  run finished and pipeline drained

Behaviour:
- Reset: all outputs, counters, pointers and registered stages are 0, and the FSM goes to IDLE. Reset mid-run discards everything.
- Reset is synchronous only; there is no asynchronous path.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
  - IDLE -> COLLECT on test_start.
  - COLLECT -> DRAIN on test_done.
  - DRAIN -> DONE after exactly 1 cycle.
  - DONE holds until test_start.
- test_start in any state, including COLLECT:
  - Synchronously clears the log, pointers, fail_count, log_overflow and bist_done.
  - Flushes the pipeline and enters COLLECT next cycle.
  - Any cmp_valid in that same cycle is dropped.
- Compare pipeline:
  - Stage 1 registers addr, element and syndrome = expected ^ actual when cmp_valid is high and the state is COLLECT.
  - cmp_valid is ignored in IDLE, DRAIN and DONE.
  - Stage 2 declares a mismatch when the syndrome is non-zero.
  - A record accepted at cycle N updates fail_count, the log and log_count, all visible at N+2.
- test_done together with cmp_valid: that record is accepted.
  - DRAIN covers the stage-2 update.
  - bist_done rises 2 cycles after test_done is sampled and stays high in DONE.
- fail_count: +1 per mismatch, saturating at all-ones (no wrap).
- Log:
  - In-order circular buffer written in order of arrival.
  - A mismatch while log_count == LOG_DEPTH is not stored and sets log_overflow (sticky until test_start or rst).
  - Pointer wrap at LOG_DEPTH is modulo with a separate full/empty distinction.
- Readout:
  - log_rd_en is honoured only in DONE with log_count > 0.
  - The next cycle gives log_rd_valid = 1 with the oldest entry on log_rd_*, and log_count decrements.
  - log_rd_en when empty or not in DONE: ignored, log_rd_valid = 0, no pointer change.
  - log_rd_* hold their last value when log_rd_valid = 0.
- bist_fail is combinational from the registered fail_count. It may assert during COLLECT and never clears except on test_start or rst.

Test Plan:
- Clean run: test_start, 16384 matching compares (expected == actual == 32'h5555_5555), test_done -> bist_done high 2 cycles after test_done; bist_fail = 0, fail_count = 0, log_count = 0, log_overflow = 0.
- Single fault: mismatch at addr 14'h0123, element 3, expected 32'hFFFF_FFFF, actual 32'hFFFF_FFFE. Then fail_count = 1 at N+2 and bist_fail = 1. After DONE, one log_rd_en gives log_rd_valid = 1, addr 14'h0123, element 3, syndrome 32'h0000_0001; log_count goes to 0.
- Overflow: 10 mismatching reads at addr 0..9 with LOG_DEPTH = 8 -> fail_count = 10, log_count = 8, log_overflow = 1; eight pops return addr 0..7 in order, and a ninth pop gives log_rd_valid = 0.
- Boundary: mismatch in the same cycle as test_done -> counted (fail_count = 1); bist_done delayed to 2 cycles after test_done; cmp_valid in DONE is ignored.
- Restart and reset: test_start mid-run after 3 fails -> counters 0, log empty, bist_done 0 the next cycle. rst asserted in DONE with 5 logged entries -> all outputs 0 on the next clk edge.
- Saturation (CNT_W = 4): 20 mismatches -> fail_count = 15 with no wrap.
